// File: rtl/one_bit_adder.sv
// Registered single-bit full adder with an optional bit-serial carry feedback path.
// Serial words are added LSB first, one bit per valid cycle, with gaps allowed between bits.
module one_bit_adder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  input  logic i_bit1,
  input  logic i_bit2,
  input  logic i_carry,
  input  logic i_serial,
  input  logic i_first,
  output logic o_sum,
  output logic o_carry,
  output logic o_valid
);

  logic sum_q;
  logic carry_q;
  logic valid_q;

  logic cin;
  logic sum_d;
  logic cout_d;

  // The internal carry register always equals the registered carry-out, so one flop serves both.
  always_comb begin
    cin    = (i_serial && !i_first) ? carry_q : i_carry;
    sum_d  = i_bit1 ^ i_bit2 ^ cin;
    cout_d = (i_bit1 & i_bit2) | (i_bit1 & cin) | (i_bit2 & cin);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else if (i_valid) begin
      sum_q   <= sum_d;
      carry_q <= cout_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = carry_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_one_bit_adder.sv
// Scoreboard bench for one_bit_adder: a behavioural model queues expected {carry, sum}
// pairs as stimulus is applied, and each scenario task pops and compares them.
module tb_one_bit_adder;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_bit1 = 1'b0;
  logic i_bit2 = 1'b0;
  logic i_carry = 1'b0;
  logic i_serial = 1'b0;
  logic i_first = 1'b0;
  logic o_sum;
  logic o_carry;
  logic o_valid;

  int checks = 0;
  int failures = 0;

  logic [1:0] sb[$];
  logic       m_carry = 1'b0;
  logic [1:0] m_held = 2'b00;

  one_bit_adder dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_bit1  (i_bit1),
    .i_bit2  (i_bit2),
    .i_carry (i_carry),
    .i_serial(i_serial),
    .i_first (i_first),
    .o_sum   (o_sum),
    .o_carry (o_carry),
    .o_valid (o_valid)
  );

  always #5 i_clk = ~i_clk;

  // Drive one cycle at the falling edge, update the model, then settle just past the rising edge.
  task automatic step(input logic r, input logic v, input logic a, input logic b,
                      input logic c, input logic s, input logic f);
    logic       cin;
    logic [1:0] res;
    @(negedge i_clk);
    i_rst = r; i_valid = v; i_bit1 = a; i_bit2 = b; i_carry = c; i_serial = s; i_first = f;
    if (r) begin
      m_carry = 1'b0;
      m_held  = 2'b00;
      sb.delete();
    end else if (v) begin
      cin = (s && !f) ? m_carry : c;
      res = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      m_carry = res[1];
      m_held  = res;
      sb.push_back(res);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] want;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({o_valid, o_carry, o_sum} !== 3'b000) begin
        failures++;
        $display("FAIL reset_edge%0d: got v/c/s=%b, required 000", k, {o_valid, o_carry, o_sum});
      end
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== {1'b1, want}) begin
      failures++;
      $display("FAIL reset_release: got v/c/s=%b, required %b", {o_valid, o_carry, o_sum},
               {1'b1, want});
    end
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release_const: got v/c/s=%b, required 100", {o_valid, o_carry, o_sum});
    end
  endtask

  task automatic test_parallel();
    logic [1:0] ptab[8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    logic [1:0] want;
    logic [2:0] abc;
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step(1'b0, 1'b1, abc[2], abc[1], abc[0], 1'b0, 1'b0);
      want = sb.pop_front();
      checks++;
      if ({o_valid, o_carry, o_sum} !== {1'b1, want}) begin
        failures++;
        $display("FAIL parallel_%b: got v/c/s=%b, required %b", abc, {o_valid, o_carry, o_sum},
                 {1'b1, want});
      end
      checks++;
      if ({o_carry, o_sum} !== ptab[i]) begin
        failures++;
        $display("FAIL parallel_table_%b: got c/s=%b, required %b", abc, {o_carry, o_sum}, ptab[i]);
      end
    end
  endtask

  // Adds a 4-bit word serially; optional gap cycles follow bit 1 with junk on the ignored inputs.
  task automatic test_serial(input logic [3:0] a, input logic [3:0] b, input logic cin,
                             input int gaps, input logic [4:0] total);
    logic [1:0] want;
    logic [4:0] got;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, a[i], b[i], (i == 0) ? cin : 1'($urandom), 1'b1, (i == 0));
      want = sb.pop_front();
      got[i] = o_sum;
      got[4] = o_carry;
      checks++;
      if ({o_valid, o_carry, o_sum} !== {1'b1, want}) begin
        failures++;
        $display("FAIL serial_%h_%h_bit%0d: got v/c/s=%b, required %b", a, b, i,
                 {o_valid, o_carry, o_sum}, {1'b1, want});
      end
      if (i == 1) begin
        for (int g = 0; g < gaps; g++) begin
          step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
          checks++;
          if ({o_valid, o_carry, o_sum} !== {1'b0, m_held}) begin
            failures++;
            $display("FAIL serial_gap%0d: got v/c/s=%b, required %b", g,
                     {o_valid, o_carry, o_sum}, {1'b0, m_held});
          end
        end
      end
    end
    checks++;
    if (got !== total) begin
      failures++;
      $display("FAIL serial_total_%h_%h: got %h, required %h", a, b, got, total);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [1:0] want;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== {1'b1, want}) begin
      failures++;
      $display("FAIL midword_bit1: got v/c/s=%b, required %b", {o_valid, o_carry, o_sum},
               {1'b1, want});
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b000) begin
      failures++;
      $display("FAIL midword_reset: got v/c/s=%b, required 000", {o_valid, o_carry, o_sum});
    end
    // i_carry is high here but must be ignored: serial without first uses the cleared carry.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b101 || {o_carry, o_sum} !== want) begin
      failures++;
      $display("FAIL midword_after: got v/c/s=%b, required 101", {o_valid, o_carry, o_sum});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    logic       v;
    // Parallel sets carry, serial uses it, first-with-parallel ignores it, then random traffic.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      want = sb.pop_front();
      checks++;
      if (want !== ((i == 1) ? 2'b01 : (i == 0) ? 2'b10 : (i == 2) ? 2'b00 : 2'b01)) begin
        failures++;
        $display("FAIL b2b_model%0d: got %b from scoreboard order", i, want);
      end
    end
    for (int i = 0; i < 60; i++) begin
      v = 1'($urandom_range(0, 3) != 0);
      step(1'b0, v, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (v) begin
        want = sb.pop_front();
        checks++;
        if ({o_valid, o_carry, o_sum} !== {1'b1, want}) begin
          failures++;
          $display("FAIL b2b_rand%0d: got v/c/s=%b, required %b", i, {o_valid, o_carry, o_sum},
                   {1'b1, want});
        end
      end else begin
        checks++;
        if ({o_valid, o_carry, o_sum} !== {1'b0, m_held}) begin
          failures++;
          $display("FAIL b2b_hold%0d: got v/c/s=%b, required %b", i, {o_valid, o_carry, o_sum},
                   {1'b0, m_held});
        end
      end
    end
  endtask

  task automatic test_back_to_back_outputs();
    logic [1:0] want;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b110 || {o_carry, o_sum} !== want) begin
      failures++;
      $display("FAIL switch_par: got v/c/s=%b, required 110", {o_valid, o_carry, o_sum});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b101 || {o_carry, o_sum} !== want) begin
      failures++;
      $display("FAIL switch_ser: got v/c/s=%b, required 101", {o_valid, o_carry, o_sum});
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    want = sb.pop_front();
    checks++;
    if ({o_valid, o_carry, o_sum} !== 3'b100 || {o_carry, o_sum} !== want) begin
      failures++;
      $display("FAIL first_parallel: got v/c/s=%b, required 100", {o_valid, o_carry, o_sum});
    end
  endtask

  initial begin
    test_reset();
    test_parallel();
    test_serial(4'hB, 4'h7, 1'b0, 0, 5'h12);
    test_serial(4'hB, 4'h7, 1'b0, 3, 5'h12);
    test_serial(4'hF, 4'h0, 1'b1, 0, 5'h10);
    test_reset_mid_word();
    test_back_to_back_outputs();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
